sif_modport: RTL and testbench
==============================

// Module: sif_modport
// PURPOSE
// - SIF register bridge between a host-side access port (XA) and a write-forward port (WA).
// - The XA port writes and reads a bank of 16-bit registers.
// - Every accepted XA write is mirrored one cycle later on the WA port, for downstream shadow logic.
// - Sits between the host bus agent and the downstream configuration consumer.
// PARAMETERS
// - DEPTH      16  number of 16-bit registers; legal addresses are 0..DEPTH-1 (power of 2, 2..256)
// - RST_VAL    16'h0000  reset value of every register
// PORTS
// - clk         in   1   single clock, all logic on rising edge
// - rst_n       in   1   asynchronous active-low reset
// - xa_addr     in   16  XA register address
// - xa_data_wr  in   16  XA write data
// - xa_wr_s     in   1   XA write strobe, one write per high cycle
// - xa_rd_s     in   1   XA read strobe, one read per high cycle
// - xa_data_rd  out  16  XA read data, registered
// - wa_addr     out  16  WA forwarded write address, registered
// - wa_data_wr  out  16  WA forwarded write data, registered
// - wa_wr_s     out  1   WA forwarded write strobe, registered
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - all registers go to RST_VAL;
//   - xa_data_rd, wa_addr, wa_data_wr and wa_wr_s go to 0 immediately;
//   - everything holds while rst_n=0;
//   - an in-flight read is dropped and its data is never presented.
// - Write: xa_wr_s=1 at edge N with xa_addr<DEPTH:
//   - reg[xa_addr] is updated at edge N;
//   - at edge N the WA outputs load wa_wr_s=1, wa_addr=xa_addr, wa_data_wr=xa_data_wr;
//   - these WA values are visible between edge N and edge N+1 and are sampled at edge N+1, i.e. 1-cycle latency.
// - wa_wr_s lasts one cycle per write. Back-to-back writes give a continuous wa_wr_s with per-cycle addr/data.
// - When wa_wr_s=0, wa_addr and wa_data_wr hold their last values.
// - Read: xa_rd_s=1 at edge N:
//   - xa_data_rd is loaded at edge N with reg[xa_addr];
//   - the host samples it at edge N+1, i.e. 1-cycle latency.
//   - Consecutive rd_s cycles stream one datum per cycle. xa_data_rd holds when rd_s=0.
// - Out of range (xa_addr>=DEPTH): a write is ignored and not forwarded on WA; a read returns 16'h0000.
// - wr_s and rd_s both high in the same cycle:
//   - both are serviced;
//   - read-before-write, so the read returns the pre-write value, unless SIF_RD_BYPASS_EN is defined.
// - There is no handshake or backpressure: every strobe is accepted in its cycle.
// CONFIGURATION
// - SIF_RD_BYPASS_EN defined:
//   - simultaneous wr_s and rd_s to the same in-range address returns xa_data_wr on xa_data_rd (write-through);
//   - a read at edge N+1 of an address written at edge N returns the new data.
// - SIF_RD_BYPASS_EN undefined: simultaneous wr_s and rd_s to the same address returns the old register contents.
// - The macro has no effect on the WA port.
// TESTING
// - Reset: hold rst_n=0 for 5 cycles, then release -> all outputs 0; reading addr 0..DEPTH-1 returns 16'h0000.
// - Write addr 3 data 16'hA5A5 -> at the next edge wa_wr_s=1, wa_addr=16'h0003, wa_data_wr=16'hA5A5 for exactly 1 cycle.
// - Write 16'h1111/16'h2222 to addr 1/2, then 2-cycle rd_s burst on 1,2 -> xa_data_rd=16'h1111 then 16'h2222 on consecutive edges.
// - Write addr 16'h0040 (>=DEPTH) -> no wa_wr_s; a read of 16'h0040 returns 16'h0000; the register bank is unchanged.
// - Hold reg 5=16'h0001, then wr_s+rd_s on addr 5 with data 16'h00FF -> read 16'h0001 (16'h00FF with SIF_RD_BYPASS_EN).
// - Assert rst_n=0 mid read burst -> xa_data_rd=0 at once, no stale data after release, registers=RST_VAL.

Source files
------------

// File: rtl/sif_modport.sv
// SIF register bridge: host XA port reads/writes a bank of 16-bit registers,
// and each accepted write is forwarded one cycle later on the WA port.
// Optional macro SIF_RD_BYPASS_EN: a same-address write+read returns the write data.
module sif_modport #(
  parameter int          DEPTH   = 16,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] xa_addr,
  input  logic [15:0] xa_data_wr,
  input  logic        xa_wr_s,
  input  logic        xa_rd_s,
  output logic [15:0] xa_data_rd,
  output logic [15:0] wa_addr,
  output logic [15:0] wa_data_wr,
  output logic        wa_wr_s
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   regs [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_ok;
  logic [15:0]   rd_val;

  assign in_range = (xa_addr < 16'(DEPTH));
  assign idx      = xa_addr[AW-1:0];
  assign wr_ok    = xa_wr_s && in_range;

  always_comb begin
    rd_val = 16'h0000;
    if (in_range) begin
`ifdef SIF_RD_BYPASS_EN
      if (xa_wr_s) rd_val = xa_data_wr;
      else         rd_val = regs[idx];
`else
      // Old contents: the write to the same entry lands at this same edge.
      rd_val = regs[idx];
`endif
    end
  end

  // NOTE: the bank has a defined reset value, so it is built from resettable
  // flops; a RAM macro without reset could not honour the async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
    end else if (wr_ok) begin
      // NOTE: non-blocking so a same-cycle read still sees the pre-write value.
      regs[idx] <= xa_data_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa_data_rd <= 16'h0000;
    end else if (xa_rd_s) begin
      xa_data_rd <= rd_val;
    end
  end

  // Forwarded write: strobe pulses per write, addr/data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_wr_s    <= 1'b0;
      wa_addr    <= 16'h0000;
      wa_data_wr <= 16'h0000;
    end else begin
      wa_wr_s <= wr_ok;
      if (wr_ok) begin
        wa_addr    <= xa_addr;
        wa_data_wr <= xa_data_wr;
      end
    end
  end

endmodule

// File: tb/tb_sif_modport.sv
// Self-checking bench for sif_modport: directed scenarios plus random traffic
// compared against an array-based model of the register bank and WA port.
module tb_sif_modport;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] xa_addr, xa_data_wr;
  logic        xa_wr_s, xa_rd_s;
  logic [15:0] xa_data_rd, wa_addr, wa_data_wr;
  logic        wa_wr_s;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] mem [DEPTH];
  logic [15:0] exp_rd, exp_wa_addr, exp_wa_data;
  logic        exp_wa_wr;

  sif_modport #(.DEPTH(DEPTH), .RST_VAL(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_data_rd (xa_data_rd),
    .wa_addr    (wa_addr),
    .wa_data_wr (wa_data_wr),
    .wa_wr_s    (wa_wr_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0000;
    exp_rd = 16'h0000; exp_wa_addr = 16'h0000; exp_wa_data = 16'h0000; exp_wa_wr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd"},      xa_data_rd,        exp_rd);
    check({tag, ".wa_wr"},   {15'd0, wa_wr_s},  {15'd0, exp_wa_wr});
    check({tag, ".wa_addr"}, wa_addr,           exp_wa_addr);
    check({tag, ".wa_data"}, wa_data_wr,        exp_wa_data);
  endtask

  // One clock cycle: drive strobes, advance the model, check after the edge.
  task automatic cycle(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [15:0] data, input string tag);
    bit in_rng;
    xa_wr_s = wr; xa_rd_s = rd; xa_addr = addr; xa_data_wr = data;
    in_rng = (int'(addr) < DEPTH);
    if (rd) begin
      if (!in_rng) exp_rd = 16'h0000;
`ifdef SIF_RD_BYPASS_EN
      else if (wr) exp_rd = data;
`endif
      else exp_rd = mem[int'(addr)];
    end
    exp_wa_wr = wr && in_rng;
    if (wr && in_rng) begin
      mem[int'(addr)] = data;
      exp_wa_addr = addr;
      exp_wa_data = data;
    end
    @(posedge clk); #1;
    xa_wr_s = 1'b0; xa_rd_s = 1'b0;
    check_outputs(tag);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, 16'(a), 16'h0, tag);
  endtask

  initial begin
    logic [15:0] a, d;
    logic        w, r;
    rst_n = 1'b0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = '0; xa_data_wr = '0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    read_all("post_reset_read");

    // Single write forwarded for exactly one cycle.
    cycle(1'b1, 1'b0, 16'h0003, 16'hA5A5, "wr3");
    check("wr3.wa_addr_lit", wa_addr, 16'h0003);
    check("wr3.wa_data_lit", wa_data_wr, 16'hA5A5);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "wr3_idle");

    // Back-to-back writes then a 2-cycle read burst.
    cycle(1'b1, 1'b0, 16'h0001, 16'h1111, "wr1");
    cycle(1'b1, 1'b0, 16'h0002, 16'h2222, "wr2");
    cycle(1'b0, 1'b1, 16'h0001, 16'h0000, "burst1");
    check("burst1.lit", xa_data_rd, 16'h1111);
    cycle(1'b0, 1'b1, 16'h0002, 16'h0000, "burst2");
    check("burst2.lit", xa_data_rd, 16'h2222);
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "rd_hold");

    // Out of range write and read.
    cycle(1'b1, 1'b0, 16'h0040, 16'hDEAD, "oor_wr");
    cycle(1'b0, 1'b1, 16'h0040, 16'h0000, "oor_rd");
    cycle(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, "oor_wrrd");
    read_all("oor_bank");

    // Simultaneous write and read on the same address.
    cycle(1'b1, 1'b0, 16'h0005, 16'h0001, "wr5");
    cycle(1'b1, 1'b1, 16'h0005, 16'h00FF, "wrrd5");
`ifdef SIF_RD_BYPASS_EN
    check("wrrd5.lit", xa_data_rd, 16'h00FF);
`else
    check("wrrd5.lit", xa_data_rd, 16'h0001);
`endif
    cycle(1'b0, 1'b1, 16'h0005, 16'h0000, "rd5_after");

    // Random traffic, mostly in range with occasional wide addresses.
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH + 3));
      d = 16'($urandom);
      cycle(w, r, a, d, "rand");
    end
    read_all("rand_bank");

    // Asynchronous reset in the middle of a read burst.
    cycle(1'b0, 1'b1, 16'h0001, 16'h0000, "mid1");
    xa_rd_s = 1'b1; xa_addr = 16'h0002;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    xa_rd_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, "rst_release");
    read_all("rst_bank");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
